// File: rtl/spi_block_sequencer_pkg.sv
// Shared definitions for the SPI block sequencer.
//
// Holds the default block geometry and timing, the FSM state encodings and
// the byte-order helper. Byte 0 of a block is the most significant byte and
// is sent first; received byte i lands in the same position as sent byte i.
package spi_seq_defs;

   localparam int unsigned DEF_NUM_BYTES      = 16;
   localparam int unsigned DEF_GAP_CYCLES     = 2;
   localparam int unsigned DEF_TIMEOUT_CYCLES = 64;

   typedef enum logic [2:0] {
      StIdle     = 3'd0,
      StIssue    = 3'd1,
      StWaitDone = 3'd2,
      StGap      = 3'd3,
      StResult   = 3'd4
   } seq_state_e;

   // LSB position of byte idx inside a num_bytes-wide block (byte 0 = MSB byte).
   function automatic int unsigned byte_lsb(input int unsigned num_bytes,
                                            input int unsigned idx);
      return 8 * (num_bytes - 1 - idx);
   endfunction

endpackage

// File: rtl/spi_cycle_counter.sv
// Loadable up-counter with synchronous clear and a terminal-count compare.
//
// Ports:
//   clk       system clock
//   reset     synchronous, active-high reset (count -> 0)
//   clr       synchronous clear, highest priority
//   load      load load_val (below clr)
//   load_val  value to load
//   en        count up by one (below load)
//   term_val  terminal value for the compare
//   at_term   high while the current count equals term_val
module spi_cycle_counter #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   input  logic [WIDTH-1:0] term_val,
   output logic             at_term
);

   logic [WIDTH-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (load) begin
         count_d = load_val;
      end else if (en) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign at_term = (count_q == term_val);

endmodule

// File: rtl/spi_block_sequencer.sv
// Block-to-byte sequencer sitting in front of a byte-level SPI master.
//
// Takes one NUM_BYTES block on a valid/ready handshake, issues it MSB byte
// first through the master's start/busy/done interface, and reassembles the
// received bytes into a result block. A programmable gap separates bytes and
// a per-byte timeout aborts a stalled transfer, flagging res_err.
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   blk_valid/ready/data  upstream block handshake (byte 0 = blk_data[W-1:W-8])
//   res_valid/ready/data  result block handshake (byte 0 = res_data[W-1:W-8])
//   res_err               result ended by timeout, qualified by res_valid
//   busy                  high whenever not idle
//   spi_start             one-cycle start pulse to the byte master
//   spi_tx                byte to send, held from start until done
//   spi_busy, spi_done    byte master status / one-cycle done pulse
//   spi_rx                received byte, valid in the spi_done cycle
module spi_block_sequencer
   import spi_seq_defs::*;
#(
   parameter int unsigned NUM_BYTES      = DEF_NUM_BYTES,
   parameter int unsigned GAP_CYCLES     = DEF_GAP_CYCLES,
   parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   localparam int unsigned W             = 8 * NUM_BYTES
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         blk_valid,
   output logic         blk_ready,
   input  logic [W-1:0] blk_data,
   output logic         res_valid,
   input  logic         res_ready,
   output logic [W-1:0] res_data,
   output logic         res_err,
   output logic         busy,
   output logic         spi_start,
   output logic [7:0]   spi_tx,
   input  logic         spi_busy,
   input  logic         spi_done,
   input  logic [7:0]   spi_rx
);

   localparam int unsigned CNT_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
   localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NUM_BYTES - 1);
   localparam logic [TMO_W-1:0] TMO_TERM  = TMO_W'(TIMEOUT_CYCLES - 1);
   // With no gap the GAP state is never entered; the compare value is moot.
   localparam logic [GAP_W-1:0] GAP_TERM  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   seq_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [W-1:0]     shift_q, shift_d;
   logic [W-1:0]     res_data_q, res_data_d;
   logic             res_err_q, res_err_d;
   logic             spi_start_q, spi_start_d;
   logic [7:0]       spi_tx_q, spi_tx_d;

   logic             last_byte;
   logic             tmo_expired;
   logic             gap_done;

   assign last_byte = (cnt_q == LAST_BYTE);

   // Timeout counter: zero in the first WAIT_DONE cycle (the start cycle).
   spi_cycle_counter #(
      .WIDTH (TMO_W)
   ) u_tmo_cnt (
      .clk      (clk),
      .reset    (reset),
      .clr      (state_q != StWaitDone),
      .load     (1'b0),
      .load_val ('0),
      .en       (state_q == StWaitDone),
      .term_val (TMO_TERM),
      .at_term  (tmo_expired)
   );

   // Gap counter: GAP lasts exactly GAP_CYCLES cycles.
   spi_cycle_counter #(
      .WIDTH (GAP_W)
   ) u_gap_cnt (
      .clk      (clk),
      .reset    (reset),
      .clr      (state_q != StGap),
      .load     (1'b0),
      .load_val ('0),
      .en       (state_q == StGap),
      .term_val (GAP_TERM),
      .at_term  (gap_done)
   );

   // ---------------------------------------------------------------- state
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // ----------------------------------------------------------- next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle: begin
            if (blk_valid) begin
               state_d = StIssue;
            end
         end
         StIssue: begin
            if (!spi_busy) begin
               state_d = StWaitDone;
            end
         end
         StWaitDone: begin
            // done takes priority over a coincident timeout
            if (spi_done) begin
               if (last_byte) begin
                  state_d = StResult;
               end else if (GAP_CYCLES > 0) begin
                  state_d = StGap;
               end else begin
                  state_d = StIssue;
               end
            end else if (tmo_expired) begin
               state_d = StResult;
            end
         end
         StGap: begin
            if (gap_done) begin
               state_d = StIssue;
            end
         end
         StResult: begin
            if (res_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // -------------------------------------------------------------- outputs
   always_comb begin
      blk_ready = (state_q == StIdle) && !reset;
      res_valid = (state_q == StResult);
      busy      = (state_q != StIdle);
   end

   // ------------------------------------------------------------- datapath
   always_comb begin
      cnt_d       = cnt_q;
      shift_d     = shift_q;
      res_data_d  = res_data_q;
      res_err_d   = res_err_q;
      spi_start_d = 1'b0;
      spi_tx_d    = spi_tx_q;
      case (state_q)
         StIdle: begin
            if (blk_valid) begin
               shift_d    = blk_data;
               res_data_d = '0;
               res_err_d  = 1'b0;
               cnt_d      = '0;
            end
         end
         StIssue: begin
            if (!spi_busy) begin
               spi_start_d = 1'b1;
               spi_tx_d    = shift_q[W-1 -: 8];
            end
         end
         StWaitDone: begin
            if (spi_done) begin
               for (int unsigned i = 0; i < NUM_BYTES; i++) begin
                  if (cnt_q == CNT_W'(i)) begin
                     res_data_d[byte_lsb(NUM_BYTES, i) +: 8] = spi_rx;
                  end
               end
               shift_d = shift_q << 8;
               if (!last_byte) begin
                  cnt_d = cnt_q + 1'b1;
               end
            end else if (tmo_expired) begin
               res_err_d = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q       <= '0;
         shift_q     <= '0;
         res_data_q  <= '0;
         res_err_q   <= 1'b0;
         spi_start_q <= 1'b0;
         spi_tx_q    <= 8'h00;
      end else begin
         cnt_q       <= cnt_d;
         shift_q     <= shift_d;
         res_data_q  <= res_data_d;
         res_err_q   <= res_err_d;
         spi_start_q <= spi_start_d;
         spi_tx_q    <= spi_tx_d;
      end
   end

   assign spi_start = spi_start_q;
   assign spi_tx    = spi_tx_q;
   assign res_data  = res_data_q;
   assign res_err   = res_err_q;

endmodule

// File: tb/tb_spi_block_sequencer.sv
// Directed bench for spi_block_sequencer. Instance 0 uses GAP_CYCLES=3,
// instance 1 uses GAP_CYCLES=0; both use 16 bytes and a 64-cycle timeout.
// A loopback byte-master model answers rx = tx ^ 8'hFF, done 18 cycles
// after start. Cycle numbers below are edge counts sampled on the negedge.
module tb_spi_block_sequencer;

   localparam int unsigned W = 128;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         reset;
   logic         blk_valid [2];
   logic         blk_ready [2];
   logic [W-1:0] blk_data  [2];
   logic         res_valid [2];
   logic         res_ready [2];
   logic [W-1:0] res_data  [2];
   logic         res_err   [2];
   logic         busy      [2];
   logic         spi_start [2];
   logic [7:0]   spi_tx    [2];
   logic         spi_busy  [2];
   logic         spi_done  [2];
   logic [7:0]   spi_rx    [2];

   logic         force_busy [2];
   logic         m_active   [2];
   logic [7:0]   m_tx       [2];
   int           m_tmr      [2];
   int           m_idx      [2];
   int           withhold   [2];

   int           cyc = 0;
   int           n_start [2] = '{0, 0};
   int           n_done  [2] = '{0, 0};
   int           start_cyc [2][256];
   logic [7:0]   start_tx  [2][256];
   int           done_cyc  [2][256];
   logic [7:0]   done_tx   [2][256];

   int           errors = 0;
   int           checks = 0;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      spi_block_sequencer #(
         .NUM_BYTES      (16),
         .GAP_CYCLES     ((g == 0) ? 3 : 0),
         .TIMEOUT_CYCLES (64)
      ) u_dut (
         .clk       (clk),
         .reset     (reset),
         .blk_valid (blk_valid[g]),
         .blk_ready (blk_ready[g]),
         .blk_data  (blk_data[g]),
         .res_valid (res_valid[g]),
         .res_ready (res_ready[g]),
         .res_data  (res_data[g]),
         .res_err   (res_err[g]),
         .busy      (busy[g]),
         .spi_start (spi_start[g]),
         .spi_tx    (spi_tx[g]),
         .spi_busy  (spi_busy[g]),
         .spi_done  (spi_done[g]),
         .spi_rx    (spi_rx[g])
      );
      assign spi_busy[g] = m_active[g] | force_busy[g];
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Loopback byte master; byte withhold[g] of a block never completes.
   always @(posedge clk) begin
      for (int g = 0; g < 2; g++) begin
         if (reset) begin
            m_active[g] <= 1'b0;
            spi_done[g] <= 1'b0;
            spi_rx[g]   <= 8'h00;
            m_tx[g]     <= 8'h00;
            m_tmr[g]    <= 0;
            m_idx[g]    <= 0;
         end else begin
            spi_done[g] <= 1'b0;
            if (spi_start[g]) begin
               m_idx[g] <= m_idx[g] + 1;
               if (m_idx[g] != withhold[g]) begin
                  m_active[g] <= 1'b1;
                  m_tmr[g]    <= 1;
                  m_tx[g]     <= spi_tx[g];
               end
            end else if (m_active[g]) begin
               if (m_tmr[g] == 17) begin
                  spi_done[g] <= 1'b1;
                  spi_rx[g]   <= m_tx[g] ^ 8'hFF;
                  m_active[g] <= 1'b0;
               end
               m_tmr[g] <= m_tmr[g] + 1;
            end else if (!busy[g]) begin
               m_idx[g] <= 0;
            end
         end
      end
   end

   // Event log of starts and dones.
   always @(negedge clk) begin
      for (int g = 0; g < 2; g++) begin
         if (spi_start[g] === 1'b1 && n_start[g] < 256) begin
            start_cyc[g][n_start[g]] = cyc;
            start_tx[g][n_start[g]]  = spi_tx[g];
            n_start[g]               = n_start[g] + 1;
         end
         if (spi_done[g] === 1'b1 && n_done[g] < 256) begin
            done_cyc[g][n_done[g]] = cyc;
            done_tx[g][n_done[g]]  = spi_tx[g];
            n_done[g]              = n_done[g] + 1;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, cycle=%0d", cyc);
      $fatal(1);
   end

   // ------------------------------------------------------------- helpers
   task automatic send_block(input int g, input logic [W-1:0] d, output int acc);
      int n;
      n = 0;
      @(negedge clk);
      blk_data[g]  = d;
      blk_valid[g] = 1'b1;
      while (blk_ready[g] !== 1'b1 && n < 500) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      acc          = (n < 500) ? cyc : -1;
      blk_valid[g] = 1'b0;
   endtask

   task automatic wait_res(input int g, input int budget, output int seen);
      seen = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (res_valid[g] === 1'b1) begin
            seen = cyc;
            break;
         end
      end
   endtask

   task automatic take_res(input int g);
      @(negedge clk);
      res_ready[g] = 1'b1;
      @(negedge clk);
      res_ready[g] = 1'b0;
   endtask

   // --------------------------------------------------------------- tests
   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      for (int g = 0; g < 2; g++) begin
         checks++; if (blk_ready[g] !== 1'b0) begin errors++; $display("FAIL rst_blk_ready[%0d]: got %b want 0", g, blk_ready[g]); end
         checks++; if (busy[g] !== 1'b0) begin errors++; $display("FAIL rst_busy[%0d]: got %b want 0", g, busy[g]); end
         checks++; if (res_valid[g] !== 1'b0) begin errors++; $display("FAIL rst_res_valid[%0d]: got %b want 0", g, res_valid[g]); end
         checks++; if (res_err[g] !== 1'b0) begin errors++; $display("FAIL rst_res_err[%0d]: got %b want 0", g, res_err[g]); end
         checks++; if (spi_start[g] !== 1'b0) begin errors++; $display("FAIL rst_spi_start[%0d]: got %b want 0", g, spi_start[g]); end
         checks++; if (spi_tx[g] !== 8'h00) begin errors++; $display("FAIL rst_spi_tx[%0d]: got %h want 00", g, spi_tx[g]); end
         checks++; if (res_data[g] !== '0) begin errors++; $display("FAIL rst_res_data[%0d]: got %h want 0", g, res_data[g]); end
      end
      reset = 1'b0;
      #1;
      for (int g = 0; g < 2; g++) begin
         checks++; if (blk_ready[g] !== 1'b1) begin errors++; $display("FAIL post_rst_blk_ready[%0d]: got %b want 1", g, blk_ready[g]); end
      end
   endtask

   task automatic test_loopback();
      int bs, bd, acc, seen;
      logic [W-1:0] held;
      bs = n_start[0];
      bd = n_done[0];
      send_block(0, 128'h000102030405060708090A0B0C0D0E0F, acc);
      wait_res(0, 1500, seen);
      checks++; if (seen < 0) begin errors++; $display("FAIL loop_result_seen: got none want res_valid"); end
      checks++; if (n_start[0] - bs != 16) begin errors++; $display("FAIL loop_starts: got %0d want 16", n_start[0] - bs); end
      checks++; if (start_cyc[0][bs] != acc + 1) begin errors++; $display("FAIL loop_first_start: got cyc %0d want %0d", start_cyc[0][bs], acc + 1); end
      for (int i = 0; i < 16; i++) begin
         checks++; if (start_tx[0][bs+i] !== 8'(i)) begin errors++; $display("FAIL loop_tx[%0d]: got %h want %h", i, start_tx[0][bs+i], 8'(i)); end
         checks++; if (done_tx[0][bd+i] !== start_tx[0][bs+i]) begin errors++; $display("FAIL loop_tx_stable[%0d]: got %h want %h", i, done_tx[0][bd+i], start_tx[0][bs+i]); end
      end
      // GAP=3: done in cycle D, gap D+1..D+3, issue D+4, start D+5
      for (int i = 0; i < 15; i++) begin
         checks++; if (start_cyc[0][bs+i+1] - done_cyc[0][bd+i] != 5) begin errors++; $display("FAIL gap3_spacing[%0d]: got %0d want 5", i, start_cyc[0][bs+i+1] - done_cyc[0][bd+i]); end
      end
      checks++; if (seen != done_cyc[0][bd+15] + 1) begin errors++; $display("FAIL loop_result_cycle: got %0d want %0d", seen, done_cyc[0][bd+15] + 1); end
      checks++; if (res_data[0] !== 128'hFFFEFDFCFBFAF9F8F7F6F5F4F3F2F1F0) begin errors++; $display("FAIL loop_res_data: got %h want fffefdfcfbfaf9f8f7f6f5f4f3f2f1f0", res_data[0]); end
      checks++; if (res_err[0] !== 1'b0) begin errors++; $display("FAIL loop_res_err: got %b want 0", res_err[0]); end
      held = res_data[0];
      repeat (5) begin
         @(negedge clk);
         checks++; if (res_valid[0] !== 1'b1 || res_data[0] !== held) begin errors++; $display("FAIL loop_hold: valid %b data %h want 1 %h", res_valid[0], res_data[0], held); end
      end
      take_res(0);
      checks++; if (res_valid[0] !== 1'b0 || blk_ready[0] !== 1'b1) begin errors++; $display("FAIL loop_after_take: valid %b ready %b want 0 1", res_valid[0], blk_ready[0]); end
   endtask

   task automatic test_gap0();
      int bs, bd, acc, seen;
      logic [W-1:0] blk;
      blk = 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF;
      bs = n_start[1];
      bd = n_done[1];
      send_block(1, blk, acc);
      wait_res(1, 1500, seen);
      checks++; if (seen < 0) begin errors++; $display("FAIL gap0_result_seen: got none want res_valid"); end
      checks++; if (n_start[1] - bs != 16) begin errors++; $display("FAIL gap0_starts: got %0d want 16", n_start[1] - bs); end
      checks++; if (start_cyc[1][bs] != acc + 1) begin errors++; $display("FAIL gap0_first_start: got %0d want %0d", start_cyc[1][bs], acc + 1); end
      // GAP=0: done in cycle D, issue D+1, start D+2
      for (int i = 0; i < 15; i++) begin
         checks++; if (start_cyc[1][bs+i+1] - done_cyc[1][bd+i] != 2) begin errors++; $display("FAIL gap0_spacing[%0d]: got %0d want 2", i, start_cyc[1][bs+i+1] - done_cyc[1][bd+i]); end
      end
      checks++; if (res_data[1] !== 128'h5F5E5D5C5B5A59585756555453525150) begin errors++; $display("FAIL gap0_res_data: got %h want 5f5e5d5c5b5a59585756555453525150", res_data[1]); end
      checks++; if (res_err[1] !== 1'b0) begin errors++; $display("FAIL gap0_res_err: got %b want 0", res_err[1]); end
      take_res(1);
   endtask

   task automatic test_timeout();
      int bs, bd, acc, seen;
      logic [W-1:0] exp_data;
      exp_data = {40'hFFFEFDFCFB, 88'h0};
      withhold[0] = 5;
      bs = n_start[0];
      bd = n_done[0];
      send_block(0, 128'h000102030405060708090A0B0C0D0E0F, acc);
      wait_res(0, 1000, seen);
      checks++; if (seen < 0) begin errors++; $display("FAIL tmo_result_seen: got none want res_valid"); end
      checks++; if (n_start[0] - bs != 6) begin errors++; $display("FAIL tmo_starts: got %0d want 6", n_start[0] - bs); end
      checks++; if (n_done[0] - bd != 5) begin errors++; $display("FAIL tmo_dones: got %0d want 5", n_done[0] - bd); end
      checks++; if (seen != start_cyc[0][bs+5] + 64) begin errors++; $display("FAIL tmo_latency: got %0d want %0d", seen - start_cyc[0][bs+5], 64); end
      checks++; if (res_err[0] !== 1'b1) begin errors++; $display("FAIL tmo_res_err: got %b want 1", res_err[0]); end
      checks++; if (res_data[0] !== exp_data) begin errors++; $display("FAIL tmo_res_data: got %h want %h", res_data[0], exp_data); end
      take_res(0);
      withhold[0] = -1;
   endtask

   task automatic test_busy_hold();
      int bs, acc, seen, rel;
      logic [W-1:0] blk;
      blk = 128'h112233445566778899AABBCCDDEEFF00;
      bs = n_start[0];
      force_busy[0] = 1'b1;
      send_block(0, blk, acc);
      repeat (10) @(negedge clk);
      checks++; if (n_start[0] != bs) begin errors++; $display("FAIL busy_no_start: got %0d starts want 0", n_start[0] - bs); end
      force_busy[0] = 1'b0;
      rel = cyc;
      wait_res(0, 1500, seen);
      checks++; if (seen < 0) begin errors++; $display("FAIL busy_result_seen: got none want res_valid"); end
      checks++; if (start_cyc[0][bs] != rel + 1) begin errors++; $display("FAIL busy_release_start: got %0d want %0d", start_cyc[0][bs], rel + 1); end
      checks++; if (n_start[0] - bs != 16) begin errors++; $display("FAIL busy_starts: got %0d want 16", n_start[0] - bs); end
      checks++; if (res_data[0] !== ~blk) begin errors++; $display("FAIL busy_res_data: got %h want %h", res_data[0], ~blk); end
      take_res(0);
   endtask

   task automatic test_back_to_back();
      int acc, seen, bad_ready, bad_data, acc2, bs2;
      logic [W-1:0] b1, b2, held;
      b1 = 128'h0F0E0D0C0B0A09080706050403020100;
      b2 = 128'hDEADBEEF0123456789ABCDEFCAFEF00D;
      send_block(0, b1, acc);
      wait_res(0, 1500, seen);
      checks++; if (seen < 0) begin errors++; $display("FAIL b2b_result_seen: got none want res_valid"); end
      held = res_data[0];
      blk_data[0]  = b2;
      blk_valid[0] = 1'b1;
      bad_ready = 0;
      bad_data  = 0;
      repeat (20) begin
         @(negedge clk);
         if (blk_ready[0] !== 1'b0) bad_ready++;
         if (res_data[0] !== held || res_valid[0] !== 1'b1) bad_data++;
      end
      checks++; if (bad_ready != 0) begin errors++; $display("FAIL b2b_ready_low: got %0d bad cycles want 0", bad_ready); end
      checks++; if (bad_data != 0) begin errors++; $display("FAIL b2b_data_stable: got %0d bad cycles want 0", bad_data); end
      checks++; if (res_data[0] !== ~b1) begin errors++; $display("FAIL b2b_res1: got %h want %h", res_data[0], ~b1); end
      res_ready[0] = 1'b1;
      @(negedge clk);
      res_ready[0] = 1'b0;
      checks++; if (blk_ready[0] !== 1'b1 || res_valid[0] !== 1'b0) begin errors++; $display("FAIL b2b_idle: ready %b valid %b want 1 0", blk_ready[0], res_valid[0]); end
      @(negedge clk);
      acc2 = cyc;
      bs2  = n_start[0];
      blk_valid[0] = 1'b0;
      checks++; if (busy[0] !== 1'b1 || blk_ready[0] !== 1'b0) begin errors++; $display("FAIL b2b_accept: busy %b ready %b want 1 0", busy[0], blk_ready[0]); end
      wait_res(0, 1500, seen);
      checks++; if (seen < 0) begin errors++; $display("FAIL b2b_result2_seen: got none want res_valid"); end
      checks++; if (start_cyc[0][bs2] != acc2 + 1) begin errors++; $display("FAIL b2b_first_start: got %0d want %0d", start_cyc[0][bs2], acc2 + 1); end
      checks++; if (res_data[0] !== ~b2) begin errors++; $display("FAIL b2b_res2: got %h want %h", res_data[0], ~b2); end
      take_res(0);
   endtask

   task automatic test_reset_mid();
      int bs, acc, seen, n;
      logic [W-1:0] b3, b4;
      b3 = 128'h0123456789ABCDEF0123456789ABCDEF;
      b4 = 128'h55AA55AA00FF00FF1234567890ABCDEF;
      bs = n_start[0];
      send_block(0, b3, acc);
      n = 0;
      while (n_start[0] - bs < 8 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      checks++; if (n_start[0] - bs < 8) begin errors++; $display("FAIL rmid_reach_byte7: got %0d starts want 8", n_start[0] - bs); end
      reset = 1'b1;
      @(negedge clk);
      checks++; if (busy[0] !== 1'b0 || res_valid[0] !== 1'b0) begin errors++; $display("FAIL rmid_idle: busy %b valid %b want 0 0", busy[0], res_valid[0]); end
      checks++; if (blk_ready[0] !== 1'b0) begin errors++; $display("FAIL rmid_ready_in_reset: got %b want 0", blk_ready[0]); end
      checks++; if (spi_start[0] !== 1'b0 || res_data[0] !== '0) begin errors++; $display("FAIL rmid_cleared: start %b data %h want 0 0", spi_start[0], res_data[0]); end
      reset = 1'b0;
      #1;
      checks++; if (blk_ready[0] !== 1'b1) begin errors++; $display("FAIL rmid_ready_after: got %b want 1", blk_ready[0]); end
      bs = n_start[0];
      send_block(0, b4, acc);
      wait_res(0, 1500, seen);
      checks++; if (seen < 0) begin errors++; $display("FAIL rmid_result_seen: got none want res_valid"); end
      checks++; if (n_start[0] - bs != 16) begin errors++; $display("FAIL rmid_starts: got %0d want 16", n_start[0] - bs); end
      checks++; if (res_data[0] !== ~b4 || res_err[0] !== 1'b0) begin errors++; $display("FAIL rmid_res: got %h err %b want %h err 0", res_data[0], res_err[0], ~b4); end
      take_res(0);
   endtask

   initial begin
      reset = 1'b1;
      for (int g = 0; g < 2; g++) begin
         blk_valid[g]  = 1'b0;
         blk_data[g]   = '0;
         res_ready[g]  = 1'b0;
         force_busy[g] = 1'b0;
         withhold[g]   = -1;
      end
      test_reset();
      test_loopback();
      test_gap0();
      test_timeout();
      test_busy_hold();
      test_back_to_back();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
